// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit:
// FSM states, ALU operations, mux selects and condition codes.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  function automatic logic cmd_ok(
    input logic [3:0] cmd
  );
    case (cmd)
      ALU_AND, ALU_EOR, ALU_SUB, ALU_RSB,
      ALU_ADD, ALU_ORR, ALU_MOV, CMD_CMP:
        cmd_ok = 1'b1;
      default:
        cmd_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_mc_if.sv
// Instruction/flag inputs and control outputs of the
// multicycle control unit, bundled for the datapath.
interface control_unit_mc_if;
  logic [31:0] INSTR;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [3:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  Flags;
  logic [3:0]  State;

  modport master (
    input  INSTR, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite,
    output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    output ALUControl, ImmSrc, RegSrc, Flags, State
  );

  modport slave (
    output INSTR, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite,
    input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    input  ALUControl, ImmSrc, RegSrc, Flags, State
  );
endinterface

// File: rtl/cond_check.sv
// Evaluates the instruction condition field against
// the stored {N,Z,C,V} flags.
module cond_check
  import control_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condex
);

  logic w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = i_flags;

  always_comb begin
    o_condex = 1'b0;
    case (i_cond)
      COND_EQ: o_condex = w_z;
      COND_NE: o_condex = !w_z;
      COND_CS: o_condex = w_c;
      COND_CC: o_condex = !w_c;
      COND_MI: o_condex = w_n;
      COND_PL: o_condex = !w_n;
      COND_VS: o_condex = w_v;
      COND_VC: o_condex = !w_v;
      COND_HI: o_condex = w_c & !w_z;
      COND_LS: o_condex = !w_c | w_z;
      COND_GE: o_condex = (w_n == w_v);
      COND_LT: o_condex = (w_n != w_v);
      COND_GT: o_condex = !w_z & (w_n == w_v);
      COND_LE: o_condex = w_z | (w_n != w_v);
      COND_AL: o_condex = 1'b1;
      COND_NV: o_condex = 1'b0;
      default: o_condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control unit: instruction-sequencing FSM
// plus the condition flag register.
module control_unit_mc
  import control_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  control_unit_mc_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_flags;

  logic [3:0] w_cond, w_cmd, w_rd, w_dp_alu;
  logic [1:0] w_op;
  logic       w_i, w_s, w_u, w_l;
  logic       w_condex, w_ok, w_nowrite;
  logic       w_rd15, w_flag_en;

  logic       w_pcw, w_irw, w_rw, w_mw;
  logic       w_adr, w_srca;
  logic [1:0] w_srcb, w_res;
  logic [3:0] w_alu;

  assign w_cond = bus.INSTR[31:28];
  assign w_op   = bus.INSTR[27:26];
  assign w_i    = bus.INSTR[25];
  assign w_cmd  = bus.INSTR[24:21];
  assign w_u    = bus.INSTR[23];
  assign w_s    = bus.INSTR[20];
  assign w_l    = bus.INSTR[20];
  assign w_rd   = bus.INSTR[15:12];

  assign w_rd15    = (w_rd == 4'd15);
  assign w_ok      = cmd_ok(w_cmd);
  assign w_nowrite = (w_cmd == CMD_CMP) | !w_ok;
  assign w_dp_alu  = (w_cmd == CMD_CMP) ? ALU_SUB
                                        : w_cmd;

  cond_check u_cond (
    .i_cond   (w_cond),
    .i_flags  (r_flags),
    .o_condex (w_condex)
  );

  assign w_flag_en = ((r_state == S_EXECR) ||
                      (r_state == S_EXECI)) &
                     w_s & w_condex & w_ok;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_FETCH;
      r_flags <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_flag_en)
        r_flags <= bus.ALUFlags;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    w_pcw  = 1'b0;
    w_irw  = 1'b0;
    w_rw   = 1'b0;
    w_mw   = 1'b0;
    w_adr  = 1'b0;
    w_srca = 1'b0;
    w_srcb = SRCB_REG;
    w_res  = RES_ALUOUT;
    w_alu  = ALU_AND;
    case (r_state)
      S_FETCH: begin
        w_irw  = 1'b1;
        w_pcw  = 1'b1;
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_alu  = ALU_ADD;
        w_res  = RES_ALU;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_alu  = ALU_ADD;
        w_res  = RES_ALU;
        case (w_op)
          2'b00: w_next = w_i ? S_EXECI : S_EXECR;
          2'b01: w_next = S_MEMADR;
          2'b10: w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_srcb = SRCB_IMM;
        w_alu  = w_u ? ALU_ADD : ALU_SUB;
        w_next = w_l ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr  = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res = RES_RDATA;
        w_rw  = w_condex;
        w_pcw = w_condex & w_rd15;
      end
      S_MEMWR: begin
        w_adr = 1'b1;
        w_mw  = w_condex;
      end
      S_EXECR: begin
        w_alu  = w_dp_alu;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_srcb = SRCB_IMM;
        w_alu  = w_dp_alu;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw  = w_condex & !w_nowrite;
        w_pcw = w_condex & !w_nowrite & w_rd15;
      end
      S_BRANCH: begin
        w_srcb = SRCB_IMM;
        w_alu  = ALU_ADD;
        w_res  = RES_ALU;
        w_pcw  = w_condex;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are gated so reset silences them immediately.
  assign bus.PCWrite    = w_pcw & RESET;
  assign bus.IRWrite    = w_irw & RESET;
  assign bus.RegWrite   = w_rw & RESET;
  assign bus.MemWrite   = w_mw & RESET;
  assign bus.AdrSrc     = w_adr;
  assign bus.ALUSrcA    = w_srca;
  assign bus.ALUSrcB    = w_srcb;
  assign bus.ResultSrc  = w_res;
  assign bus.ALUControl = w_alu;
  assign bus.ImmSrc     = w_op;
  assign bus.RegSrc     = {w_op == 2'b10,
                           w_op == 2'b01};
  assign bus.Flags      = r_flags;
  assign bus.State      = r_state;

endmodule

// File: doc/control_unit_mc.md
CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed constants from the shared package.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 INSTR  in  32  instruction register contents: Cond[31:28], Op[27:26], I[25], Cmd/PUBWL[24:20], S/L[20], Rd[15:12].
REQ-005 ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables.
REQ-007 AdrSrc  out  1  memory address source: 0=PC, 1=Result.
REQ-008 ALUSrcA  out  1  0=register A, 1=PC.
REQ-009 ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4.
REQ-010 ResultSrc  out  2  00=ALUOut register, 01=ReadData, 10=ALUResult direct.
REQ-011 ALUControl  out  4  ALU operation: AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, ORR 1100, MOV 1101.
REQ-012 ImmSrc  out  2  equals Op: 00=imm8, 01=imm12, 10=imm24.
REQ-013 RegSrc  out  2  combinational: [0]=(Op==01) selects Rd as source B; [1]=(Op==10) selects R15 as source A.
REQ-014 Flags  out  4  stored {N,Z,C,V}.
REQ-015 State  out  4  current state code, for debug.

Function
REQ-016 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; unlisted outputs are 0 in each state.
REQ-017 FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; next state DECODE.
REQ-018 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; next state: Op=01->MEMADR, Op=00&I=1->EXECI, Op=00&I=0->EXECR, Op=10->BRANCH, Op=11->FETCH (no-op).
REQ-019 MEMADR: ALUSrcB=01, ALUControl=ADD if U=1 else SUB; next state MEMRD if L=1, else MEMWR.
REQ-020 MEMRD: AdrSrc=1, ResultSrc=00; next state MEMWB. MEMWB: ResultSrc=01, RegWrite=CondEx, PCWrite=CondEx&(Rd==15); next state FETCH.
REQ-021 MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondEx; next state FETCH.
REQ-022 EXECR: ALUSrcB=00; EXECI: ALUSrcB=01; both drive ALUControl=Cmd, except CMP(1010)->SUB; next state ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=CondEx&!NoWrite, PCWrite=CondEx&!NoWrite&(Rd==15); NoWrite=1 for CMP and all unsupported Cmd codes; next state FETCH.
REQ-024 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx; next state FETCH; the link bit is ignored.
REQ-025 Flags SHALL load ALUFlags on the edge ending EXECR/EXECI when S=1, CondEx=1 and Cmd is supported; otherwise Flags hold.
REQ-026 CondEx is combinational from Cond and the stored Flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
REQ-027 A false condition SHALL suppress RegWrite, MemWrite, the PCWrite of the branch/writeback states, and the flag update, but SHALL NOT change the state sequence.
REQ-028 Latency in cycles: data-processing 4, LDR 5, STR 4, B 3, Op=11 2.

Reset
REQ-029 While RESET=0: State=FETCH, Flags=0000, and PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; all other outputs take their FETCH values.
REQ-030 Reset asserted mid-instruction SHALL abort that instruction immediately; the first rising edge after release executes FETCH.

Structure
REQ-031 The package control_pkg SHALL hold the state encoding, ALUControl codes, the ALUSrcB/ResultSrc encodings and the Cond codes.
REQ-032 Condition evaluation SHALL be a sub-module named cond_check (Cond, Flags -> CondEx); the FSM and flag register stay in control_unit_mc.

Verification
REQ-033 Reset: drive RESET=0 while in MEMRD -> State=FETCH, enables 0, Flags=0000; after release, first cycle IRWrite=1 and PCWrite=1.
REQ-034 INSTR=E2821005 (ADD R1,R2,#5) -> FETCH, DECODE, EXECI (ALUControl=0100, ALUSrcB=01), ALUWB (RegWrite=1), then FETCH on cycle 5.
REQ-035 INSTR=E1510002 (CMP) with ALUFlags=0100 -> Flags=0100 and RegWrite=0 in ALUWB; then 0A000002 -> PCWrite=1 in BRANCH, and 1A000002 -> PCWrite=0.
REQ-036 INSTR=E5910004 (LDR) -> 5 states, AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB; E5810004 -> MemWrite=1 only in MEMWR with ALUControl=0100; E5010004 -> ALUControl=0010 in MEMADR.
REQ-037 INSTR=12821005 with Z=1 -> 4 cycles, RegWrite=0 throughout; E591F000 -> PCWrite=1 in MEMWB.
REQ-038 INSTR=EC000000 (Op=11) -> FETCH, DECODE, FETCH, with no RegWrite, MemWrite or Flags change.
